ascon128a_frame_loader: RTL

- Upstream/around stage for the one-block Ascon-128a encryption core (`top`: SK, N, A, P in; C, T out).
- Assembles a 512-bit job (SK, N, A, P) from a 32-bit valid/ready word stream and holds it stable on the core inputs.
- Waits a fixed core latency, then captures C and T into output registers.
- Presents C and T on a valid/ready result port, so the combinational/fixed-latency core can be driven from a narrow bus instead of a file-fed bench.

---
 rtl/ascon128a_frame_loader_pkg.sv | 32 +++
 rtl/ascon128a_frame_loader_packer.sv | 40 ++++
 rtl/ascon128a_frame_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/ascon128a_frame_loader_pkg.sv
// Shared constants for the Ascon-128a frame loader: FSM states, field indices,
// counter widths and the 32-bit lane insertion helper.
package ascon128a_loader_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_JOB = 16;
  localparam int WC_W          = 4;
  localparam int WAIT_W        = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] F_SK = 2'd0;
  localparam logic [1:0] F_N  = 2'd1;
  localparam logic [1:0] F_A  = 2'd2;
  localparam logic [1:0] F_P  = 2'd3;

  // Lane 3 is bits [127:96], so the first word of a field is its MSW.
  function automatic logic [127:0] put_lane(input logic [127:0] cur,
                                            input logic [1:0] lane,
                                            input logic [WORD_W-1:0] w);
    logic [127:0] r;
    r = cur;
    r[lane*32 +: 32] = w;
    return r;
  endfunction

endpackage

// File: rtl/ascon128a_frame_loader_packer.sv
// ascon_word_packer: writes one 32-bit word into SK/N/A/P selected by the
// 4-bit word index (field = idx/4, lane = 3 - idx%4).
module ascon_word_packer
  import ascon128a_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [WC_W-1:0]   idx,
  input  logic [WORD_W-1:0] data,
  output logic [127:0]      sk,
  output logic [127:0]      n,
  output logic [127:0]      a,
  output logic [127:0]      p
);

  logic [1:0] field;
  logic [1:0] lane;

  assign field = idx[3:2];
  assign lane  = 2'd3 - idx[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk <= 128'd0;
      n  <= 128'd0;
      a  <= 128'd0;
      p  <= 128'd0;
    end else if (we) begin
      case (field)
        F_SK:    sk <= put_lane(sk, lane, data);
        F_N:     n  <= put_lane(n, lane, data);
        F_A:     a  <= put_lane(a, lane, data);
        F_P:     p  <= put_lane(p, lane, data);
        default: sk <= sk;
      endcase
    end
  end

endmodule

// File: rtl/ascon128a_frame_loader.sv
// Frame loader around the one-block Ascon-128a core: assembles SK/N/A/P from a
// 32-bit stream, waits CORE_CYCLES, captures C/T. Option: ASCON_LOADER_KEY_REUSE_EN.
module ascon128a_frame_loader
  import ascon128a_loader_pkg::*;
#(
  parameter int CORE_CYCLES = 45
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef ASCON_LOADER_KEY_REUSE_EN
  input  logic              key_keep,
`endif
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [127:0]      SK,
  output logic [127:0]      N,
  output logic [127:0]      A,
  output logic [127:0]      P,
  output logic              ld_start,
  input  logic [127:0]      C_core,
  input  logic [127:0]      T_core,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [127:0]      C_out,
  output logic [127:0]      T_out,
  output logic              busy
);

  state_t            state;
  state_t            next_state;
  logic [WC_W-1:0]   wc;
  logic [WC_W-1:0]   widx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              skip_key;
  logic              last_word;
  logic              wait_done;

  assign accept = in_valid & in_ready;

`ifdef ASCON_LOADER_KEY_REUSE_EN
  // Word 0 with key_keep set is redirected to N's MSW, leaving SK untouched.
  assign skip_key = key_keep && (wc == 4'd0);
`else
  assign skip_key = 1'b0;
`endif

  assign widx      = skip_key ? 4'd4 : wc;
  assign last_word = (widx == WC_W'(WORDS_PER_JOB - 1));
  assign wait_done = (wait_cnt == WAIT_W'(CORE_CYCLES - 1));

  ascon_word_packer u_packer (
    .clk  (CLK),
    .rst  (RST),
    .we   (accept),
    .idx  (widx),
    .data (in_data),
    .sk   (SK),
    .n    (N),
    .a    (A),
    .p    (P)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD: begin
        if (accept && last_word) next_state = ST_START;
        else                     next_state = ST_LOAD;
      end
      ST_START: next_state = ST_WAIT;
      ST_WAIT: begin
        if (wait_done) next_state = ST_HOLD;
        else           next_state = ST_WAIT;
      end
      ST_HOLD: begin
        if (res_valid && res_ready) next_state = ST_LOAD;
        else                        next_state = ST_HOLD;
      end
      default: next_state = ST_LOAD;
    endcase
  end

  // Handshake/status outputs are registered copies of the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_LOAD;
      in_ready  <= 1'b0;
      ld_start  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == ST_LOAD);
      ld_start  <= (next_state == ST_START);
      res_valid <= (next_state == ST_HOLD);
      busy      <= (next_state != ST_LOAD);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wc       <= 4'd0;
      wait_cnt <= {WAIT_W{1'b0}};
      C_out    <= 128'd0;
      T_out    <= 128'd0;
    end else begin
      if (accept) wc <= widx + 4'd1;
      if (state == ST_START) wait_cnt <= {WAIT_W{1'b0}};
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (state == ST_WAIT && wait_done) begin
        C_out <= C_core;
        T_out <= T_core;
      end
    end
  end

endmodule
